model_standard_fnn_output_stage: RTL and testbench

//  Consumer end of the standard FNN controller output: reads the controller vector h (L words), then

---
 rtl/model_standard_fnn_pkg.sv | 40 ++++
 rtl/model_standard_fnn_mac.sv | 42 ++++
 rtl/model_standard_fnn_output_stage.sv | 117 +++++++++++
 tb/tb_model_standard_fnn_output_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/model_standard_fnn_pkg.sv
// rtl/model_standard_fnn_pkg.sv - shared types, widths and saturation helper for the FNN output stage
package model_standard_fnn_pkg;

    localparam int DATA_SIZE_DEF = 64;
    localparam int L_DEF         = 64;
    localparam int Y_DEF         = 64;

    // Widest intermediate the saturation helper handles; must exceed any accumulator width in use.
    localparam int SAT_W = 256;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_H     = 2'd1,
        ACCUMULATE = 2'd2,
        EMIT       = 2'd3
    } fsm_state_t;

    // Full-precision signed dot product: product doubles the width, L terms add clog2(L) bits.
    function automatic int acc_width(input int data_size, input int l);
        return 2 * data_size + $clog2(l);
    endfunction

    localparam int ACC_W_DEF = 2 * DATA_SIZE_DEF + $clog2(L_DEF);

    // Clamp a sign-extended value into the signed range of a width-bit word.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] value,
                                                         input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/model_standard_fnn_mac.sv
// rtl/model_standard_fnn_mac.sv - signed multiply-accumulate with saturating registered result
module model_standard_fnn_mac
    import model_standard_fnn_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int L         = L_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        acc_en,
    input  logic                        last,
    input  logic signed [DATA_SIZE-1:0] a,
    input  logic signed [DATA_SIZE-1:0] b,
    output logic signed [DATA_SIZE-1:0] y
);

    localparam int PROD_W = 2 * DATA_SIZE;
    localparam int ACC_W  = acc_width(DATA_SIZE, L) > PROD_W ? acc_width(DATA_SIZE, L) : PROD_W + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;

    assign prod = PROD_W'(a) * PROD_W'(b);
    assign sum  = acc + ACC_W'(prod);

    // The final column folds straight into the output so the row total never waits a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            y   <= '0;
        end else if (acc_en) begin
            if (last) begin
                acc <= '0;
                y   <= DATA_SIZE'(saturate(SAT_W'(sum), DATA_SIZE));
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/model_standard_fnn_output_stage.sv
// rtl/model_standard_fnn_output_stage.sv - loads h, streams U row-major and emits saturated y = U*h
module model_standard_fnn_output_stage
    import model_standard_fnn_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int L         = L_DEF,
    parameter int Y         = Y_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 H_IN_ENABLE,
    output logic                 H_IN_READY,
    input  logic [DATA_SIZE-1:0] H_IN,
    input  logic                 U_IN_ENABLE,
    output logic                 U_IN_READY,
    input  logic [DATA_SIZE-1:0] U_IN,
    output logic                 Y_OUT_ENABLE,
    input  logic                 Y_OUT_READY,
    output logic [DATA_SIZE-1:0] Y_OUT
);

    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int YW = (Y > 1) ? $clog2(Y) : 1;

    fsm_state_t state;
    fsm_state_t state_next;

    logic [LW-1:0]        l_cnt;
    logic [YW-1:0]        j_cnt;
    logic [DATA_SIZE-1:0] h_buf [L];

    logic h_acc;
    logic u_acc;
    logic y_acc;
    logic l_last;
    logic j_last;

    assign h_acc  = H_IN_READY && H_IN_ENABLE;
    assign u_acc  = U_IN_READY && U_IN_ENABLE;
    assign y_acc  = Y_OUT_ENABLE && Y_OUT_READY;
    assign l_last = (l_cnt == LW'(L - 1));
    assign j_last = (j_cnt == YW'(Y - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            l_cnt <= '0;
            j_cnt <= '0;
        end else begin
            state <= state_next;
            if (h_acc || u_acc) begin
                l_cnt <= l_last ? '0 : l_cnt + LW'(1);
            end
            if (y_acc) begin
                j_cnt <= j_last ? '0 : j_cnt + YW'(1);
            end
        end
    end

    // h is always rewritten in full before it is read, so the buffer needs no reset.
    always_ff @(posedge CLK) begin
        if (h_acc) begin
            h_buf[l_cnt] <= H_IN;
        end
    end

    always_comb begin
        state_next   = state;
        READY        = 1'b0;
        H_IN_READY   = 1'b0;
        U_IN_READY   = 1'b0;
        Y_OUT_ENABLE = 1'b0;
        case (state)
            IDLE: begin
                READY = 1'b1;
                if (START) begin
                    state_next = LOAD_H;
                end
            end
            LOAD_H: begin
                H_IN_READY = 1'b1;
                if (H_IN_ENABLE && l_last) begin
                    state_next = ACCUMULATE;
                end
            end
            ACCUMULATE: begin
                U_IN_READY = 1'b1;
                if (U_IN_ENABLE && l_last) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                Y_OUT_ENABLE = 1'b1;
                if (Y_OUT_READY) begin
                    state_next = j_last ? IDLE : ACCUMULATE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    model_standard_fnn_mac #(
        .DATA_SIZE(DATA_SIZE),
        .L        (L)
    ) u_mac (
        .clk   (CLK),
        .rst   (RST),
        .acc_en(u_acc),
        .last  (l_last),
        .a     (U_IN),
        .b     (h_buf[l_cnt]),
        .y     (Y_OUT)
    );

endmodule

// File: tb/tb_model_standard_fnn_output_stage.sv
// tb/tb_model_standard_fnn_output_stage.sv - randomized self-checking bench for the FNN output stage
module tb_model_standard_fnn_output_stage;

    localparam int DS = 64;
    typedef logic signed [DS-1:0] word_t;

    localparam word_t MAXW = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam word_t MINW = 64'sh8000_0000_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    logic start = 1'b0, ready, h_en = 1'b0, h_rdy, u_en = 1'b0, u_rdy, y_en, y_rdy = 1'b0;
    logic [DS-1:0] h_in = '0, u_in = '0, y_out;

    logic start1 = 1'b0, ready1, h_en1 = 1'b0, h_rdy1, u_en1 = 1'b0, u_rdy1, y_en1, y_rdy1 = 1'b0;
    logic [DS-1:0] h_in1 = '0, u_in1 = '0, y_out1;

    int total = 0;
    int bad   = 0;

    model_standard_fnn_output_stage #(.DATA_SIZE(DS), .L(4), .Y(2)) dut (
        .CLK(clk), .RST(rst), .START(start), .READY(ready),
        .H_IN_ENABLE(h_en), .H_IN_READY(h_rdy), .H_IN(h_in),
        .U_IN_ENABLE(u_en), .U_IN_READY(u_rdy), .U_IN(u_in),
        .Y_OUT_ENABLE(y_en), .Y_OUT_READY(y_rdy), .Y_OUT(y_out)
    );

    model_standard_fnn_output_stage #(.DATA_SIZE(DS), .L(1), .Y(3)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .READY(ready1),
        .H_IN_ENABLE(h_en1), .H_IN_READY(h_rdy1), .H_IN(h_in1),
        .U_IN_ENABLE(u_en1), .U_IN_READY(u_rdy1), .U_IN(u_in1),
        .Y_OUT_ENABLE(y_en1), .Y_OUT_READY(y_rdy1), .Y_OUT(y_out1)
    );

    // y(j) = clamp(sum_l U(j,l) * h(l)) using wide plain arithmetic.
    function automatic word_t model_y(input word_t hv[$], input word_t uv[$], input int j);
        logic signed [191:0] s;
        s = '0;
        for (int l = 0; l < hv.size(); l++) begin
            s = s + 192'(hv[l]) * 192'(uv[j * hv.size() + l]);
        end
        if (s > 192'(MAXW)) return MAXW;
        if (s < 192'(MINW)) return MINW;
        return word_t'(s);
    endfunction

    // Drives one L=4, Y=2 job; abort_u >= 0 stops after that many U accepts without finishing.
    task automatic run_job(input word_t hv[$], input word_t uv[$], input int gap, input int stall,
                           input bit noise, input int abort_u, output word_t yv[$]);
        int  hi = 0, ui = 0, yi = 0, cyc = 0, waitc = 0;
        bit  have_y = 1'b0, just_acc = 1'b0;
        word_t held = '0;
        yv = {};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (yi < 2 && cyc < 3000) begin
            if (abort_u >= 0 && ui == abort_u) break;
            cyc++;
            if (just_acc) begin
                total++;
                if (y_en !== 1'b0) begin
                    bad++;
                    $display("FAIL y_enable_drop: got %b required 0", y_en);
                end
                just_acc = 1'b0;
            end
            h_en = (hi < 4) && ($urandom_range(99) >= gap);
            h_in = (hi < 4) ? hv[hi] : {$urandom, $urandom};
            if (noise && hi < 4) begin
                u_en = 1'b1;
                u_in = {$urandom, $urandom};
                total++;
                if (u_rdy !== 1'b0) begin
                    bad++;
                    $display("FAIL u_ready_in_load_h: got %b required 0", u_rdy);
                end
            end else begin
                u_en = (hi == 4) && (ui < 8) && ($urandom_range(99) >= gap);
                u_in = (ui < 8) ? uv[ui] : {$urandom, $urandom};
            end
            start = noise && ($urandom_range(1) == 1);
            if (y_en) begin
                if (!have_y) begin
                    held   = y_out;
                    have_y = 1'b1;
                    waitc  = 0;
                end else begin
                    total++;
                    if (y_out !== held) begin
                        bad++;
                        $display("FAIL y_stable: got %0d required %0d", $signed(y_out), held);
                    end
                end
                y_rdy = (waitc >= stall);
                waitc++;
                if (y_rdy) begin
                    yv.push_back(y_out);
                    yi++;
                    have_y   = 1'b0;
                    just_acc = 1'b1;
                end
            end else begin
                y_rdy = ($urandom_range(1) == 1);
            end
            if (h_en && h_rdy) hi++;
            if (u_en && u_rdy) ui++;
            @(negedge clk);
        end
        start = 1'b0;
        h_en  = 1'b0;
        u_en  = 1'b0;
        y_rdy = 1'b0;
        if (abort_u < 0) begin
            total++;
            if (yi < 2) begin
                bad++;
                $display("FAIL job_timeout: got %0d y words required 2", yi);
            end else if (y_en !== 1'b0 || ready !== 1'b1) begin
                bad++;
                $display("FAIL ready_after_last_y: got ready=%b y_en=%b required ready=1 y_en=0",
                         ready, y_en);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({ready, h_rdy, u_rdy, y_en} !== 4'b1000 || y_out !== '0) begin
            bad++;
            $display("FAIL reset_state: got rdy/h/u/y=%b y_out=%0d required 1000 y_out=0",
                     {ready, h_rdy, u_rdy, y_en}, y_out);
        end
    endtask

    task automatic test_basic(input int gap, input int stall, input bit noise, input string tag);
        word_t hv[$], uv[$], yv[$];
        hv = '{1, 2, 3, 4};
        uv = '{1, 1, 1, 1, 2, 0, -1, 3};
        run_job(hv, uv, gap, stall, noise, -1, yv);
        for (int j = 0; j < 2; j++) begin
            total++;
            if (yv.size() <= j || yv[j] !== model_y(hv, uv, j) || model_y(hv, uv, j) !== word_t'(10 + j)) begin
                bad++;
                $display("FAIL %s_y%0d: got %0d required %0d", tag, j,
                         (yv.size() > j) ? yv[j] : word_t'(0), 10 + j);
            end
        end
    endtask

    task automatic test_saturation;
        word_t hv[$], uv[$], yv[$];
        hv = '{64'sh4000_0000_0000_0000, 64'sh4000_0000_0000_0000, 0, 0};
        uv = '{4, 4, 0, 0, -4, -4, 0, 0};
        run_job(hv, uv, 0, 0, 1'b0, -1, yv);
        total++;
        if (yv.size() < 2 || yv[0] !== MAXW || yv[1] !== MINW) begin
            bad++;
            $display("FAIL saturation: got %0d,%0d required %0d,%0d",
                     (yv.size() > 0) ? yv[0] : word_t'(0), (yv.size() > 1) ? yv[1] : word_t'(0),
                     MAXW, MINW);
        end
    endtask

    task automatic test_reset_mid;
        word_t hv[$], uv[$], yv[$];
        hv = '{7, 7, 7, 7};
        uv = '{9, 9, 9, 9, 9, 9, 9, 9};
        run_job(hv, uv, 0, 0, 1'b0, 2, yv);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({ready, h_rdy, u_rdy, y_en} !== 4'b1000 || y_out !== '0) begin
            bad++;
            $display("FAIL reset_mid: got rdy/h/u/y=%b y_out=%0d required 1000 y_out=0",
                     {ready, h_rdy, u_rdy, y_en}, y_out);
        end
        test_basic(0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random;
        word_t hv[$], uv[$], yv[$];
        for (int k = 0; k < 6; k++) begin
            hv = {};
            uv = {};
            for (int i = 0; i < 4; i++)
                hv.push_back((k % 2 == 0) ? word_t'(int'($urandom_range(2000)) - 1000)
                                          : word_t'({$urandom, $urandom}));
            for (int i = 0; i < 8; i++)
                uv.push_back((k % 2 == 0) ? word_t'(int'($urandom_range(2000)) - 1000)
                                          : word_t'({$urandom, $urandom}));
            run_job(hv, uv, int'($urandom_range(60)), int'($urandom_range(3)), k[0], -1, yv);
            for (int j = 0; j < 2; j++) begin
                total++;
                if (yv.size() <= j || yv[j] !== model_y(hv, uv, j)) begin
                    bad++;
                    $display("FAIL random%0d_y%0d: got %0d required %0d", k, j,
                             (yv.size() > j) ? yv[j] : word_t'(0), model_y(hv, uv, j));
                end
            end
        end
    endtask

    task automatic test_l1;
        word_t hv[$], uv[$], yv[$];
        int hi = 0, ui = 0, cyc = 0;
        hv = '{-5};
        uv = '{1, 2, -3};
        yv = {};
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (yv.size() < 3 && cyc < 200) begin
            cyc++;
            h_en1  = (hi < 1);
            h_in1  = hv[0];
            u_en1  = (hi == 1) && (ui < 3);
            u_in1  = (ui < 3) ? uv[ui] : '0;
            y_rdy1 = 1'b1;
            if (y_en1) yv.push_back(y_out1);
            if (h_en1 && h_rdy1) hi++;
            if (u_en1 && u_rdy1) ui++;
            @(negedge clk);
        end
        h_en1  = 1'b0;
        u_en1  = 1'b0;
        y_rdy1 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            total++;
            if (yv.size() <= j || yv[j] !== model_y(hv, uv, j)) begin
                bad++;
                $display("FAIL l1_y%0d: got %0d required %0d", j,
                         (yv.size() > j) ? yv[j] : word_t'(0), model_y(hv, uv, j));
            end
        end
        total++;
        if (ready1 !== 1'b1) begin
            bad++;
            $display("FAIL l1_ready: got %b required 1", ready1);
        end
    endtask

    initial begin
        test_reset();
        test_basic(0, 0, 1'b0, "basic");
        test_basic(40, 3, 1'b0, "stall");
        test_saturation();
        test_reset_mid();
        test_basic(30, 1, 1'b1, "ignored");
        test_random();
        test_l1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
